// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if
//   Bundles the PS/2 pins and the decoded-event outputs of ps2_scancode_rx.
//   slave  : receiver side (takes the pins, drives the event outputs)
//   master : keyboard/consumer side (drives the pins, reads the events)
// Signals:
//   ps2_clk, ps2_data : raw PS/2 pins, asynchronous, idle high
//   scancode[15:0]    : held code of the currently pressed key, 0 when none
//   evt_valid         : one-cycle strobe per make/break event
//   evt_code[15:0]    : code of the last event
//   evt_break         : 1 = release, 0 = press (valid with evt_valid)
//   frame_err         : one-cycle strobe on parity/stop/timeout error
interface ps2_scancode_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] scancode;
  logic        evt_valid;
  logic [15:0] evt_code;
  logic        evt_break;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  scancode, evt_valid, evt_code, evt_break, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output scancode, evt_valid, evt_code, evt_break, frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   PS/2 keyboard receiver: synchronises the raw pins, deserialises 11-bit
//   device-to-host frames (start, 8 data LSB first, odd parity, stop),
//   and assembles E0/F0 prefixed sequences into 16-bit make/break events.
//   Keeps a held scancode of the key currently pressed.
// Parameters:
//   TIMEOUT_CYCLES : clk cycles without a PS/2 falling edge before a
//                    partial frame is abandoned (PS2_TIMEOUT_EN only)
// Build option:
//   PS2_TIMEOUT_EN : define to enable the partial-frame timeout counter
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ps2_scancode_rx_if.slave (pins in, event outputs out)
module ps2_scancode_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  ps2_scancode_rx_if.slave         bus
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // Synchronisers (reset to bus-idle 1 so reset release never looks like an edge)
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;

  // Frame path
  state_e      state_q,    state_d;
  logic [2:0]  bit_cnt_q,  bit_cnt_d;
  logic [7:0]  shift_q,    shift_d;
  logic        par_q,      par_d;
  logic        byte_rdy_q, byte_rdy_d;
  logic [7:0]  rx_byte_q,  rx_byte_d;
  logic        frame_err_q, frame_err_d;

  // Assembly path
  logic        ext_q,       ext_d;
  logic        brk_q,       brk_d;
  logic [15:0] scancode_q,  scancode_d;
  logic        evt_valid_q, evt_valid_d;
  logic [15:0] evt_code_q,  evt_code_d;
  logic        evt_break_q, evt_break_d;

  logic        fall;
  logic        sample;
  logic [15:0] code;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign fall   = clk_prev_q & ~clk_s2_q;
  assign sample = dat_s2_q;

  // Frame deserialiser
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    rx_byte_d   = rx_byte_q;
    byte_rdy_d  = 1'b0;
    frame_err_d = 1'b0;

    if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!sample) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {sample, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = sample;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (sample && ((^shift_q) ^ par_q)) begin
            byte_rdy_d = 1'b1;
            rx_byte_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef PS2_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    if (fall) begin
      to_cnt_d = '0;
    end else if (state_q != S_IDLE) begin
      // A real edge in the same cycle wins over the timeout.
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
        state_d     = S_IDLE;
        frame_err_d = 1'b1;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
`endif
  end

  // Prefix assembly and held scancode
  assign code = ext_q ? {8'hE0, rx_byte_q} : {8'h00, rx_byte_q};

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    scancode_d  = scancode_q;
    evt_code_d  = evt_code_q;
    evt_break_d = evt_break_q;
    evt_valid_d = 1'b0;

    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_rdy_q) begin
      if (rx_byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        evt_valid_d = 1'b1;
        evt_code_d  = code;
        evt_break_d = brk_q;
        ext_d       = 1'b0;
        brk_d       = 1'b0;
        if (!brk_q) begin
          scancode_d = code;
        end else if (code == scancode_q) begin
          // Only the release of the held key clears it.
          scancode_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      byte_rdy_q  <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      scancode_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_break_q <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      clk_s1_q    <= bus.ps2_clk;
      clk_s2_q    <= clk_s1_q;
      clk_prev_q  <= clk_s2_q;
      dat_s1_q    <= bus.ps2_data;
      dat_s2_q    <= dat_s1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      byte_rdy_q  <= byte_rdy_d;
      rx_byte_q   <= rx_byte_d;
      frame_err_q <= frame_err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      scancode_q  <= scancode_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_break_q <= evt_break_d;
`ifdef PS2_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign bus.scancode  = scancode_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.evt_break = evt_break_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Testbench for ps2_scancode_rx: directed PS/2 frames with hand-computed
// expected events, scancode, error strobes and latencies.
module tb_ps2_scancode_rx;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TO = 200;
`else
  localparam int unsigned TO = 50000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_scancode_rx_if bus ();

  ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling clk edge
  logic [15:0] ev_code_q[$];
  logic        ev_brk_q[$];
  int          ferr_cnt  = 0;
  int          ferr_wide = 0;
  int          evt_wide  = 0;
  time         t_evt     = 0;
  time         t_ferr    = 0;
  logic        prev_ferr = 1'b0;
  logic        prev_evt  = 1'b0;

  always @(negedge clk) begin
    if (bus.evt_valid === 1'b1) begin
      ev_code_q.push_back(bus.evt_code);
      ev_brk_q.push_back(bus.evt_break);
      t_evt = $time;
      if (prev_evt) evt_wide++;
    end
    if (bus.frame_err === 1'b1) begin
      ferr_cnt++;
      t_ferr = $time;
      if (prev_ferr) ferr_wide++;
    end
    prev_evt  = (bus.evt_valid === 1'b1);
    prev_ferr = (bus.frame_err === 1'b1);
  end

  time t_stop = 0;
  time t_last = 0;

  // Sends the first nbits of an 11-bit frame; half-period 20 clk cycles.
  task automatic send_frame(input logic [7:0] b, input int nbits, input logic bad_par,
                            input logic stop);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      #100;
      bus.ps2_clk = 1'b0;
      t_last = $time;
      if (i == 10) t_stop = $time;
      #200;
      bus.ps2_clk = 1'b1;
      #100;
    end
    bus.ps2_data = 1'b1;
    #400;
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 11, 1'b0, 1'b1);
  endtask

  task automatic expect_event(input string tag, input logic [15:0] code, input logic brk);
    check({tag, "_n"}, ev_code_q.size(), 1);
    if (ev_code_q.size() > 0) begin
      check({tag, "_code"}, ev_code_q.pop_front(), code);
      check({tag, "_brk"}, ev_brk_q.pop_front(), brk);
    end
    ev_code_q.delete();
    ev_brk_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sc"}, bus.scancode, 16'h0000);
    check({tag, "_ev"}, bus.evt_valid, 1'b0);
    check({tag, "_code"}, bus.evt_code, 16'h0000);
    check({tag, "_brk"}, bus.evt_break, 1'b0);
    check({tag, "_ferr"}, bus.frame_err, 1'b0);
  endtask

  int ferr0;

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single make 1C; stop-pin fall at a negedge -> evt visible 4 clk later
    good(8'h1C);
    expect_event("make1c", 16'h001C, 1'b0);
    check("sc_1c", bus.scancode, 16'h001C);
    check("lat_1c", ((t_evt - t_stop) >= 40 && (t_evt - t_stop) <= 50), 1'b1);

    // Extended make then extended break
    good(8'hE0); good(8'h6B);
    expect_event("e06b_make", 16'hE06B, 1'b0);
    check("sc_e06b", bus.scancode, 16'hE06B);
    good(8'hE0); good(8'hF0); good(8'h6B);
    expect_event("e06b_brk", 16'hE06B, 1'b1);
    check("sc_e06b_rel", bus.scancode, 16'h0000);

    // Release of a key that is not the held one leaves scancode alone
    good(8'hE0); good(8'h75);
    expect_event("e075_make", 16'hE075, 1'b0);
    check("sc_e075", bus.scancode, 16'hE075);
    good(8'hE0); good(8'h74);
    expect_event("e074_make", 16'hE074, 1'b0);
    check("sc_e074", bus.scancode, 16'hE074);
    good(8'hE0); good(8'hF0); good(8'h75);
    expect_event("e075_brk", 16'hE075, 1'b1);
    check("sc_keep_e074", bus.scancode, 16'hE074);

    // Typematic repeat still produces an event
    good(8'hE0); good(8'h74);
    expect_event("e074_rep", 16'hE074, 1'b0);

    // Parity error
    ferr0 = ferr_cnt;
    send_frame(8'h1C, 11, 1'b1, 1'b1);
    check("par_ferr", ferr_cnt - ferr0, 1);
    check("par_noev", ev_code_q.size(), 0);
    check("par_sc", bus.scancode, 16'hE074);

    // E0 prefix discarded by a bad-stop frame
    ferr0 = ferr_cnt;
    good(8'hE0);
    send_frame(8'h12, 11, 1'b0, 1'b0);
    check("stop_ferr", ferr_cnt - ferr0, 1);
    good(8'h6B);
    expect_event("after_err", 16'h006B, 1'b0);
    check("sc_006b", bus.scancode, 16'h006B);

    // Truncated frame: start + 4 data bits, then silence
    ferr0 = ferr_cnt;
    send_frame(8'hA5, 5, 1'b0, 1'b1);
    repeat (300) @(negedge clk);
`ifdef PS2_TIMEOUT_EN
    check("to_ferr", ferr_cnt - ferr0, 1);
    check("to_time", ((t_ferr - t_last) >= 2000 && (t_ferr - t_last) <= 2100), 1'b1);
    good(8'h29);
    expect_event("after_to", 16'h0029, 1'b0);
`else
    check("no_to_ferr", ferr_cnt - ferr0, 0);
    check("no_to_ev", ev_code_q.size(), 0);
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // Reset during data bit 5, then a clean frame
    ferr0 = ferr_cnt;
    send_frame(8'h5A, 6, 1'b0, 1'b1);
    bus.ps2_data = 1'b1;
    #100 bus.ps2_clk = 1'b0;
    #53 rst = 1'b1;
    #47 bus.ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_noerr", ferr_cnt - ferr0, 0);
    ev_code_q.delete();
    ev_brk_q.delete();
    good(8'h72);
    expect_event("after_rst", 16'h0072, 1'b0);
    check("sc_0072", bus.scancode, 16'h0072);

    check("ferr_width", ferr_wide, 0);
    check("evt_width", evt_wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
